// File: rtl/branch_predictor_pkg.sv
`include "control_macros.sv"
`default_nettype none
// ==========================================================================
// branch_predictor_pkg : shared types and counter-update helper
// Revision             : 1.0
// ==========================================================================
package branch_predictor_pkg;

    localparam logic [1:0] c_branch_none = `BRANCH_NONE;
    localparam logic [1:0] c_branch_cond = `BRANCH_COND;
    localparam logic [1:0] c_branch_jump = `BRANCH_JUMP;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    // Saturating 2-bit update; jumps always force strongly-taken.
    function automatic logic [1:0] f_ctr_next(input logic [1:0] ctr,
                                              input logic       is_jump,
                                              input logic       taken);
        logic [1:0] res;
        res = ctr;
        if (is_jump)
            res = `CTR_STRONG_T;
        else if (taken && ctr != `CTR_STRONG_T)
            res = ctr + 2'd1;
        else if (!taken && ctr != `CTR_STRONG_NT)
            res = ctr - 2'd1;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_table.sv
`include "control_macros.sv"
`default_nettype none
// ==========================================================================
// bp_table : direct-mapped BTB + 2-bit counters, async read, sync update
// Revision : 1.0
// ==========================================================================
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [INDEX_BITS-1:0] i_rd_idx,
    input  logic [TAG_BITS-1:0]   i_rd_tag,
    output logic                  o_rd_hit,
    output logic [1:0]            o_rd_ctr,
    output logic [31:0]           o_rd_target,
    input  logic                  i_upd_en,
    input  logic                  i_upd_jump,
    input  logic                  i_upd_taken,
    input  logic [INDEX_BITS-1:0] i_upd_idx,
    input  logic [TAG_BITS-1:0]   i_upd_tag,
    input  logic [31:0]           i_upd_target
);

    localparam int c_entries = 1 << INDEX_BITS;

    logic [c_entries-1:0] r_valid;
    logic [1:0]           r_ctr    [c_entries];
    logic [TAG_BITS-1:0]  r_tag    [c_entries];
    logic [31:0]          r_target [c_entries];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_valid <= '0;
            for (int i = 0; i < c_entries; i++)
                r_ctr[i] <= `CTR_RESET;
        end else if (i_upd_en) begin
            r_ctr[i_upd_idx] <= f_ctr_next(r_ctr[i_upd_idx], i_upd_jump, i_upd_taken);
            if (i_upd_taken)
                r_valid[i_upd_idx] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; valid bits gate its use.
    always_ff @(posedge clk_i) begin
        if (i_upd_en && i_upd_taken) begin
            r_tag[i_upd_idx]    <= i_upd_tag;
            r_target[i_upd_idx] <= i_upd_target;
        end
    end

    assign o_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_ctr    = r_ctr[i_rd_idx];
    assign o_rd_target = r_target[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/control_macros.sv
`ifndef CONTROL_MACROS_SV
`define CONTROL_MACROS_SV
// ==========================================================================
// control_macros : branch class encodings and 2-bit counter constants
// Revision       : 1.0
// ==========================================================================
`define BRANCH_NONE   2'b00
`define BRANCH_COND   2'b01
`define BRANCH_JUMP   2'b10

`define CTR_STRONG_NT 2'b00
`define CTR_WEAK_NT   2'b01
`define CTR_WEAK_T    2'b10
`define CTR_STRONG_T  2'b11
`define CTR_RESET     `CTR_WEAK_NT
`endif

// File: rtl/branch_predictor.sv
`include "control_macros.sv"
`default_nettype none
// ==========================================================================
// branch_predictor : F-stage prediction, D-stage copy, E-stage resolve/train
// Revision         : 1.0
// ==========================================================================
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] pc_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    output logic        pc_src_pred_f_o,
    output logic [31:0] pred_pc_target_f_o,
    output logic        pc_src_pred_d_o,
    output logic [31:0] pred_pc_target_d_o,
    input  logic        valid_e_i,
    input  logic [1:0]  branch_op_e_i,
    input  logic        branch_taken_e_i,
    input  logic        pc_src_pred_e_i,
    input  logic        target_match_e_i,
    input  logic [31:0] pc_e_i,
    input  logic [31:0] pc_plus4_e_i,
    input  logic [31:0] pc_target_e_i,
    output logic        mispredict_e_o,
    output logic [31:0] redirect_pc_e_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] mispredict_count_o
);

    localparam int c_tag_lo = INDEX_BITS + 2;
    localparam int c_tag_hi = INDEX_BITS + TAG_BITS + 1;

    logic                  w_hit_f;
    logic [1:0]            w_ctr_f;
    logic [31:0]           w_btb_target_f;
    logic                  w_br_e;
    logic                  w_mispredict_e;
    pred_t                 w_pred_f;
    pred_t                 r_pred_d;
    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;
    logic                  w_unused_bits;

    bp_table #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_table (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .i_rd_idx     (pc_f_i[INDEX_BITS+1:2]),
        .i_rd_tag     (pc_f_i[c_tag_hi:c_tag_lo]),
        .o_rd_hit     (w_hit_f),
        .o_rd_ctr     (w_ctr_f),
        .o_rd_target  (w_btb_target_f),
        .i_upd_en     (w_br_e),
        .i_upd_jump   (branch_op_e_i == c_branch_jump),
        .i_upd_taken  (branch_taken_e_i),
        .i_upd_idx    (pc_e_i[INDEX_BITS+1:2]),
        .i_upd_tag    (pc_e_i[c_tag_hi:c_tag_lo]),
        .i_upd_target (pc_target_e_i)
    );

    // Outputs are forced to zero while reset is asserted.
    assign w_pred_f.taken  = reset_ni && w_hit_f && w_ctr_f[1];
    assign w_pred_f.target = !reset_ni ? 32'd0 : (w_hit_f ? w_btb_target_f : pc_f_i + 32'd4);

    assign pc_src_pred_f_o    = w_pred_f.taken;
    assign pred_pc_target_f_o = w_pred_f.target;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            r_pred_d <= '0;
        else if (flush_d_i)
            r_pred_d <= '0;
        else if (!stall_d_i)
            r_pred_d <= w_pred_f;
    end

    assign pc_src_pred_d_o    = r_pred_d.taken;
    assign pred_pc_target_d_o = r_pred_d.target;

    assign w_br_e         = valid_e_i && (branch_op_e_i != c_branch_none);
    assign w_mispredict_e = w_br_e && ((branch_taken_e_i != pc_src_pred_e_i) ||
                                       (branch_taken_e_i && !target_match_e_i));

    assign mispredict_e_o  = reset_ni && w_mispredict_e;
    assign redirect_pc_e_o = branch_taken_e_i ? pc_target_e_i : pc_plus4_e_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_br_e)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_mispredict_e)
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign branch_count_o     = r_branch_count;
    assign mispredict_count_o = r_mispredict_count;

    assign w_unused_bits = ^{pc_f_i[1:0], pc_f_i[31:c_tag_hi+1],
                             pc_e_i[1:0], pc_e_i[31:c_tag_hi+1]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ==========================================================================
// tb_branch_predictor : directed vector table, hand sequences, random vs model
// Revision            : 1.0
// ==========================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b1;
    logic [31:0] pc_f_i = '0;
    logic        stall_d_i = 1'b0, flush_d_i = 1'b0;
    logic        pc_src_pred_f_o, pc_src_pred_d_o, mispredict_e_o;
    logic [31:0] pred_pc_target_f_o, pred_pc_target_d_o, redirect_pc_e_o;
    logic [31:0] branch_count_o, mispredict_count_o;
    logic        valid_e_i = 1'b0, branch_taken_e_i = 1'b0;
    logic        pc_src_pred_e_i = 1'b0, target_match_e_i = 1'b0;
    logic [1:0]  branch_op_e_i = 2'b00;
    logic [31:0] pc_e_i = '0, pc_plus4_e_i = '0, pc_target_e_i = '0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .pc_f_i(pc_f_i),
        .stall_d_i(stall_d_i), .flush_d_i(flush_d_i),
        .pc_src_pred_f_o(pc_src_pred_f_o), .pred_pc_target_f_o(pred_pc_target_f_o),
        .pc_src_pred_d_o(pc_src_pred_d_o), .pred_pc_target_d_o(pred_pc_target_d_o),
        .valid_e_i(valid_e_i), .branch_op_e_i(branch_op_e_i),
        .branch_taken_e_i(branch_taken_e_i), .pc_src_pred_e_i(pc_src_pred_e_i),
        .target_match_e_i(target_match_e_i), .pc_e_i(pc_e_i),
        .pc_plus4_e_i(pc_plus4_e_i), .pc_target_e_i(pc_target_e_i),
        .mispredict_e_o(mispredict_e_o), .redirect_pc_e_o(redirect_pc_e_o),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pcf, input logic ve, input logic [1:0] op,
                         input logic tk, input logic pe, input logic tm,
                         input logic [31:0] pce, input logic [31:0] tg);
        pc_f_i = pcf; valid_e_i = ve; branch_op_e_i = op; branch_taken_e_i = tk;
        pc_src_pred_e_i = pe; target_match_e_i = tm; pc_e_i = pce;
        pc_plus4_e_i = pce + 32'd4; pc_target_e_i = tg;
    endtask

    typedef struct {
        logic [31:0] pc_f;
        logic        ve;
        logic [1:0]  op;
        logic        tk, pe, tm;
        logic [31:0] pc_e, tgt;
        logic        x_src;
        logic [31:0] x_tgt;
        logic        x_mis;
        logic [31:0] x_redir;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pcf, input logic ve, input logic [1:0] op,
                                input logic tk, input logic pe, input logic tm,
                                input logic [31:0] pce, input logic [31:0] tg,
                                input logic xs, input logic [31:0] xt,
                                input logic xm, input logic [31:0] xr);
        vec_t v;
        v.pc_f = pcf; v.ve = ve; v.op = op; v.tk = tk; v.pe = pe; v.tm = tm;
        v.pc_e = pce; v.tgt = tg; v.x_src = xs; v.x_tgt = xt; v.x_mis = xm; v.x_redir = xr;
        return v;
    endfunction

    // Behavioural reference: plain arrays indexed by pc/4 mod 64, tag = pc/256 mod 256.
    bit          m_val [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    bit          md_src;
    logic [31:0] md_tgt;
    logic [31:0] m_bc, m_mc;

    function automatic void m_lookup(input logic [31:0] pc, output bit s, output logic [31:0] t);
        int idx;
        bit hit;
        idx = int'((pc / 4) % 64);
        hit = m_val[idx] && (m_tag[idx] == (pc / 256) % 256);
        s = hit && (m_ctr[idx] >= 2);
        t = hit ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] rpc();
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
             | (32'($urandom_range(0, 1)) << 20);
    endfunction

    vec_t vecs[14];

    initial begin
        int bc, mc;
        bit s, mis, br;
        logic [31:0] t, redir, last_pce;

        vecs[0]  = mk(32'h100, 0, 2'd0, 0, 0, 0, 32'h100, 32'h200, 0, 32'h104, 0, 32'h104);
        vecs[1]  = mk(32'h100, 1, 2'd1, 1, 0, 0, 32'h100, 32'h200, 0, 32'h104, 1, 32'h200);
        vecs[2]  = mk(32'h100, 0, 2'd0, 0, 0, 0, 32'h100, 32'h200, 1, 32'h200, 0, 32'h104);
        vecs[3]  = mk(32'h100, 1, 2'd1, 0, 1, 1, 32'h100, 32'h200, 1, 32'h200, 1, 32'h104);
        vecs[4]  = mk(32'h100, 1, 2'd1, 0, 0, 1, 32'h100, 32'h200, 0, 32'h200, 0, 32'h104);
        vecs[5]  = mk(32'h100, 1, 2'd1, 0, 0, 1, 32'h100, 32'h200, 0, 32'h200, 0, 32'h104);
        vecs[6]  = mk(32'h100, 0, 2'd0, 0, 0, 0, 32'h100, 32'h200, 0, 32'h200, 0, 32'h104);
        vecs[7]  = mk(32'h040, 1, 2'd2, 1, 1, 0, 32'h040, 32'h080, 0, 32'h044, 1, 32'h080);
        vecs[8]  = mk(32'h040, 0, 2'd0, 0, 0, 0, 32'h040, 32'h080, 1, 32'h080, 0, 32'h044);
        vecs[9]  = mk(32'h200, 1, 2'd1, 1, 0, 0, 32'h100, 32'h300, 0, 32'h204, 1, 32'h300);
        vecs[10] = mk(32'h200, 1, 2'd1, 1, 0, 0, 32'h200, 32'h400, 0, 32'h204, 1, 32'h400);
        vecs[11] = mk(32'h100, 0, 2'd0, 0, 0, 0, 32'h200, 32'h400, 0, 32'h104, 0, 32'h204);
        vecs[12] = mk(32'h200, 0, 2'd0, 0, 0, 0, 32'h200, 32'h400, 1, 32'h400, 0, 32'h204);
        vecs[13] = mk(32'h040, 1, 2'd0, 1, 0, 0, 32'h040, 32'h500, 1, 32'h080, 0, 32'h500);

        // Reset with a live taken branch at E: only redirect may be non-zero.
        drive(32'h100, 1, 2'd1, 1, 0, 0, 32'h100, 32'h200);
        #2 reset_ni = 1'b0;
        #1;
        chk("rst_src_f", pc_src_pred_f_o, 0);
        chk("rst_tgt_f", pred_pc_target_f_o, 0);
        chk("rst_src_d", pc_src_pred_d_o, 0);
        chk("rst_tgt_d", pred_pc_target_d_o, 0);
        chk("rst_mis", mispredict_e_o, 0);
        chk("rst_redir", redirect_pc_e_o, 32'h200);
        chk("rst_bc", branch_count_o, 0);
        chk("rst_mc", mispredict_count_o, 0);
        repeat (2) @(posedge clk);
        drive(32'h100, 0, 2'd0, 0, 0, 0, 32'h100, 32'h200);
        stall_d_i = 1'b1;
        @(negedge clk) reset_ni = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_src_f", pc_src_pred_f_o, 0);
        chk("post_rst_tgt_f", pred_pc_target_f_o, 32'h104);
        chk("post_rst_bc", branch_count_o, 0);
        chk("post_rst_mc", mispredict_count_o, 0);
        stall_d_i = 1'b0;

        bc = 0; mc = 0;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].pc_f, vecs[i].ve, vecs[i].op, vecs[i].tk, vecs[i].pe,
                  vecs[i].tm, vecs[i].pc_e, vecs[i].tgt);
            @(negedge clk);
            chk($sformatf("vec%0d_src_f", i), pc_src_pred_f_o, vecs[i].x_src);
            chk($sformatf("vec%0d_tgt_f", i), pred_pc_target_f_o, vecs[i].x_tgt);
            chk($sformatf("vec%0d_mis", i), mispredict_e_o, vecs[i].x_mis);
            chk($sformatf("vec%0d_redir", i), redirect_pc_e_o, vecs[i].x_redir);
            chk($sformatf("vec%0d_src_d", i), pc_src_pred_d_o, i == 0 ? 1'b0 : vecs[i-1].x_src);
            chk($sformatf("vec%0d_tgt_d", i), pred_pc_target_d_o, i == 0 ? 32'd0 : vecs[i-1].x_tgt);
            chk($sformatf("vec%0d_bc", i), branch_count_o, bc);
            chk($sformatf("vec%0d_mc", i), mispredict_count_o, mc);
            if (vecs[i].ve && vecs[i].op != 2'd0) bc++;
            if (vecs[i].x_mis) mc++;
            @(posedge clk); #1;
        end

        // Stall holds D, flush beats stall.
        drive(32'h200, 0, 2'd0, 0, 0, 0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("stall_pre_src", pc_src_pred_d_o, 1);
        chk("stall_pre_tgt", pred_pc_target_d_o, 32'h400);
        stall_d_i = 1'b1; pc_f_i = 32'h100;
        @(posedge clk); #1;
        chk("stall1_tgt", pred_pc_target_d_o, 32'h400);
        pc_f_i = 32'h300;
        @(posedge clk); #1;
        chk("stall2_src", pc_src_pred_d_o, 1);
        chk("stall2_tgt", pred_pc_target_d_o, 32'h400);
        flush_d_i = 1'b1;
        @(posedge clk); #1;
        chk("flush_src", pc_src_pred_d_o, 0);
        chk("flush_tgt", pred_pc_target_d_o, 0);
        stall_d_i = 1'b0; flush_d_i = 1'b0; pc_f_i = 32'h40;
        @(posedge clk); #1;
        chk("resume_src", pc_src_pred_d_o, 1);
        chk("resume_tgt", pred_pc_target_d_o, 32'h80);
        chk("pre_rst_bc", branch_count_o, 7);
        chk("pre_rst_mc", mispredict_count_o, 5);

        // Asynchronous reset between clock edges.
        #2 reset_ni = 1'b0;
        #1;
        chk("async_src_d", pc_src_pred_d_o, 0);
        chk("async_tgt_d", pred_pc_target_d_o, 0);
        chk("async_bc", branch_count_o, 0);
        chk("async_mc", mispredict_count_o, 0);
        chk("async_src_f", pc_src_pred_f_o, 0);
        chk("async_tgt_f", pred_pc_target_f_o, 0);
        stall_d_i = 1'b1;
        @(negedge clk) reset_ni = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m_val[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = '0;
        end
        md_src = 0; md_tgt = '0; m_bc = '0; m_mc = '0;
        last_pce = 32'h100;
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            logic [1:0] op;
            logic tk;
            op = 2'($urandom_range(0, 2));
            tk = (op == 2'd2) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(($urandom_range(0, 1) != 0) ? last_pce : rpc(),
                  $urandom_range(0, 3) != 0, op, tk,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rpc(), $urandom & 32'hFFFC);
            last_pce = pc_e_i;
            stall_d_i = ($urandom_range(0, 7) == 0);
            flush_d_i = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            m_lookup(pc_f_i, s, t);
            br = valid_e_i && (branch_op_e_i != 2'd0);
            mis = br && ((branch_taken_e_i != pc_src_pred_e_i) ||
                         (branch_taken_e_i && !target_match_e_i));
            redir = branch_taken_e_i ? pc_target_e_i : pc_plus4_e_i;
            chk("rnd_src_f", pc_src_pred_f_o, s);
            chk("rnd_tgt_f", pred_pc_target_f_o, t);
            chk("rnd_src_d", pc_src_pred_d_o, md_src);
            chk("rnd_tgt_d", pred_pc_target_d_o, md_tgt);
            chk("rnd_mis", mispredict_e_o, mis);
            chk("rnd_redir", redirect_pc_e_o, redir);
            chk("rnd_bc", branch_count_o, m_bc);
            chk("rnd_mc", mispredict_count_o, m_mc);
            @(posedge clk); #1;
            if (flush_d_i) begin
                md_src = 0; md_tgt = '0;
            end else if (!stall_d_i) begin
                md_src = s; md_tgt = t;
            end
            if (br) begin
                int idx;
                idx = int'((pc_e_i / 4) % 64);
                if (branch_op_e_i == 2'd2) m_ctr[idx] = 3;
                else if (branch_taken_e_i) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                else m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                if (branch_taken_e_i) begin
                    m_val[idx] = 1;
                    m_tag[idx] = (pc_e_i / 256) % 256;
                    m_tgt[idx] = pc_target_e_i;
                end
                m_bc = m_bc + 32'd1;
            end
            if (mis) m_mc = m_mc + 32'd1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
